hazard_scoreboard: RTL and testbench

- Parametrised second-generation hazard unit for the in-order RISC-V core.
- Combines three functions:
  - N-stage forwarding selection with per-stage "result ready" qualification, which generalises load-use detection.
  - A per-register countdown scoreboard for variable-latency operations (mul/div, long loads).
  - A branch-resolution state machine that holds fetch until EX resolves the branch.
- Sits beside the decode stage and drives the fetch, IF/ID and pipeline enables.

---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/hazard_sb_counter.sv | 32 +++
 rtl/hazard_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: forward-select encoding and branch FSM states.
package hazard_scoreboard_pkg;

    // forward_rs* value meaning "read the register file"; k > 0 selects stage k
    localparam int unsigned FWD_REGFILE = 0;

    typedef enum logic [0:0] {
        BR_IDLE    = 1'b0,
        BR_RESOLVE = 1'b1
    } br_state_e;

endpackage

// File: rtl/hazard_sb_counter.sv
// Countdown counter for one architectural register's pending long-latency result.
// Ports:
//   clk, reset  : core clock, synchronous active-high reset
//   load        : a long op targeting this register issues this cycle
//   load_val    : cycles the result stays unavailable after the issue cycle
//   busy_c      : counter non-zero (result not yet in the register file)
module hazard_sb_counter #(
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    output logic          busy_c
);

    logic [LW-1:0] count;

    // A fresh load wins over the free-running decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - LW'(1);
        end
    end

    assign busy_c = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside decode: N-stage forwarding with readiness qualification,
// per-register countdown scoreboard for long ops, and a branch-resolve FSM.
// Ports:
//   clk, reset                       : core clock, synchronous active-high reset
//   id_*                             : instruction currently in ID
//   ex_branch_resolved/should_branch : branch outcome from EX
//   stage_write_reg/rd/ready         : forwarding sources, stage 1 (EX) in the LSBs
//   imem_wait, dmem_wait             : memory stalls
//   stall, flush                     : ID/EX bubble, IF/ID kill
//   pc_write_enable, ifid_write_enable, pipe_enable : pipeline enables
//   forward_rs1/rs2                  : 0 = register file, k = stage k
//   sb_busy                          : any long op still outstanding
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int unsigned NUM_REGS    = 32,
    parameter  int unsigned FWD_STAGES  = 3,
    parameter  int unsigned MAX_LATENCY = 15,
    localparam int unsigned RW          = $clog2(NUM_REGS),
    localparam int unsigned LW          = $clog2(MAX_LATENCY + 1),
    localparam int unsigned FSW         = $clog2(FWD_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [RW-1:0]            id_rs1,
    input  logic [RW-1:0]            id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic [RW-1:0]            id_rd,
    input  logic                     id_write_reg,
    input  logic [LW-1:0]            id_long_lat,
    input  logic                     id_is_branch,
    input  logic                     ex_branch_resolved,
    input  logic                     ex_should_branch,
    input  logic [FWD_STAGES-1:0]    stage_write_reg,
    input  logic [FWD_STAGES*RW-1:0] stage_rd,
    input  logic [FWD_STAGES-1:0]    stage_ready,
    input  logic                     imem_wait,
    input  logic                     dmem_wait,
    output logic                     stall,
    output logic                     flush,
    output logic                     pc_write_enable,
    output logic                     ifid_write_enable,
    output logic                     pipe_enable,
    output logic [FSW-1:0]           forward_rs1,
    output logic [FSW-1:0]           forward_rs2,
    output logic                     sb_busy
);

    br_state_e         state;
    logic [RW-1:0]     src      [2];
    logic [1:0]        src_live;
    logic [1:0]        fwd_hit;
    logic [1:0]        fwd_rdy;
    logic [FSW-1:0]    fwd_idx  [2];
    logic [1:0]        load_use;
    logic [1:0]        raw;
    logic              waw;
    logic              data_hazard;
    logic              resolving;
    logic              branch_hold;
    logic              issue;
    logic              issue_long;
    logic [LW-1:0]     lat_sat;
    logic [LW-1:0]     sb_load_val;
    logic [NUM_REGS-1:0] sb_pending;

    assign pipe_enable = ~(imem_wait | dmem_wait);

    assign src[0]      = id_rs1;
    assign src[1]      = id_rs2;
    assign src_live[0] = id_uses_rs1 & (id_rs1 != '0);
    assign src_live[1] = id_uses_rs2 & (id_rs2 != '0);

    // Nearest matching stage wins: scan from farthest to nearest so the lowest k overwrites
    always_comb begin
        fwd_hit = '0;
        fwd_rdy = '0;
        for (int s = 0; s < 2; s++) begin
            fwd_idx[s] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (stage_write_reg[k] && (stage_rd[k*RW +: RW] == src[s])) begin
                    fwd_hit[s] = 1'b1;
                    fwd_rdy[s] = stage_ready[k];
                    fwd_idx[s] = FSW'(k + 1);
                end
            end
        end
    end

    // A matching but not-yet-ready producer is a load-use hazard; no forwarding then
    always_comb begin
        forward_rs1 = FSW'(FWD_REGFILE);
        forward_rs2 = FSW'(FWD_REGFILE);
        load_use    = '0;
        raw         = '0;
        for (int s = 0; s < 2; s++) begin
            load_use[s] = src_live[s] & fwd_hit[s] & ~fwd_rdy[s];
            raw[s]      = src_live[s] & sb_pending[src[s]];
        end
        if (src_live[0] && fwd_hit[0] && fwd_rdy[0]) begin
            forward_rs1 = fwd_idx[0];
        end
        if (src_live[1] && fwd_hit[1] && fwd_rdy[1]) begin
            forward_rs2 = fwd_idx[1];
        end
    end

    assign waw         = id_write_reg & sb_pending[id_rd];
    assign data_hazard = (|load_use) | (|raw) | waw;

    assign resolving   = (state == BR_RESOLVE) & ex_branch_resolved & pipe_enable;
    assign branch_hold = (state == BR_RESOLVE) & ~resolving;

    // A taken branch kills the ID instruction, so that instruction neither stalls nor issues
    assign flush             = resolving & ex_should_branch;
    assign stall             = id_valid & ~flush & (data_hazard | branch_hold);
    assign pc_write_enable   = flush | ~(stall | branch_hold);
    assign ifid_write_enable = flush | ~(stall | branch_hold);
    assign issue             = id_valid & ~stall & pipe_enable & ~flush;

    // Branch FSM: hold fetch from branch issue until EX resolves it
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BR_IDLE;
        end else begin
            case (state)
                BR_IDLE: begin
                    if (issue && id_is_branch) begin
                        state <= BR_RESOLVE;
                    end
                end
                BR_RESOLVE: begin
                    if (resolving) begin
                        state <= (issue && id_is_branch) ? BR_RESOLVE : BR_IDLE;
                    end
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

    // Latency L means readable L cycles after issue, so the counter holds L-1
    // remaining busy cycles once loaded
    assign lat_sat     = ({1'b0, id_long_lat} > (LW+1)'(MAX_LATENCY)) ? LW'(MAX_LATENCY)
                                                                       : id_long_lat;
    assign sb_load_val = lat_sat - LW'(1);
    assign issue_long  = issue & id_write_reg & (id_rd != '0) & (id_long_lat != '0);

    assign sb_pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        hazard_sb_counter #(
            .LW (LW)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .load     (issue_long & (id_rd == RW'(r))),
            .load_val (sb_load_val),
            .busy_c   (sb_pending[r])
        );
    end

    assign sb_busy = |sb_pending;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, scoreboard, branch FSM.
module tb_hazard_scoreboard;

    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned FWD_STAGES  = 3;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned RW          = 5;
    localparam int unsigned LW          = 4;
    localparam int unsigned FSW         = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     id_valid;
    logic [RW-1:0]            id_rs1, id_rs2, id_rd;
    logic                     id_uses_rs1, id_uses_rs2, id_write_reg;
    logic [LW-1:0]            id_long_lat;
    logic                     id_is_branch;
    logic                     ex_branch_resolved, ex_should_branch;
    logic [FWD_STAGES-1:0]    stage_write_reg, stage_ready;
    logic [FWD_STAGES*RW-1:0] stage_rd;
    logic                     imem_wait, dmem_wait;
    logic                     stall, flush, pc_write_enable, ifid_write_enable, pipe_enable;
    logic [FSW-1:0]           forward_rs1, forward_rs2;
    logic                     sb_busy;

    int checks = 0;
    int errors = 0;
    int n;

    hazard_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .FWD_STAGES  (FWD_STAGES),
        .MAX_LATENCY (MAX_LATENCY)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .id_valid           (id_valid),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_uses_rs1        (id_uses_rs1),
        .id_uses_rs2        (id_uses_rs2),
        .id_rd              (id_rd),
        .id_write_reg       (id_write_reg),
        .id_long_lat        (id_long_lat),
        .id_is_branch       (id_is_branch),
        .ex_branch_resolved (ex_branch_resolved),
        .ex_should_branch   (ex_should_branch),
        .stage_write_reg    (stage_write_reg),
        .stage_rd           (stage_rd),
        .stage_ready        (stage_ready),
        .imem_wait          (imem_wait),
        .dmem_wait          (dmem_wait),
        .stall              (stall),
        .flush              (flush),
        .pc_write_enable    (pc_write_enable),
        .ifid_write_enable  (ifid_write_enable),
        .pipe_enable        (pipe_enable),
        .forward_rs1        (forward_rs1),
        .forward_rs2        (forward_rs2),
        .sb_busy            (sb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_write_reg = 0; id_long_lat = 0;
        id_is_branch = 0; ex_branch_resolved = 0; ex_should_branch = 0;
        stage_write_reg = 0; stage_rd = 0; stage_ready = 0;
        imem_wait = 0; dmem_wait = 0;
    endtask

    task automatic set_stage(input int k, input logic wr, input logic [RW-1:0] rd, input logic rdy);
        stage_write_reg[k-1]      = wr;
        stage_rd[(k-1)*RW +: RW]  = rd;
        stage_ready[k-1]          = rdy;
    endtask

    // Put a long op in ID for one cycle (it issues at the next edge)
    task automatic issue_long(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
        clear_inputs();
        id_valid = 1; id_write_reg = 1; id_rd = rd; id_long_lat = lat;
        settle();
        chk("long_issue_stall", stall, 0);
        tick();
    endtask

    // Count consecutive stall cycles with the current ID contents, bounded
    task automatic count_stalls(output int cnt);
        cnt = 0;
        settle();
        while (stall === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
            settle();
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        tick();
        settle();
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_pc_we", pc_write_enable, 1);
        chk("rst_ifid_we", ifid_write_enable, 1);
        chk("rst_pipe_en", pipe_enable, 1);
        chk("rst_fwd1", forward_rs1, 0);
        chk("rst_fwd2", forward_rs2, 0);
        chk("rst_sb_busy", sb_busy, 0);

        // Forwarding: EX writes x5
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5;
        set_stage(1, 1, 5, 1);
        settle();
        chk("fwd_ex", forward_rs1, 1);
        chk("fwd_ex_stall", stall, 0);
        set_stage(2, 1, 5, 1);
        settle();
        chk("fwd_nearest", forward_rs1, 1);
        set_stage(1, 0, 0, 0);
        set_stage(2, 0, 0, 0);
        set_stage(3, 1, 5, 1);
        settle();
        chk("fwd_stage3", forward_rs1, 3);
        id_rs1 = 0;
        set_stage(1, 1, 0, 1);
        settle();
        chk("fwd_x0", forward_rs1, 0);

        // Load-use on rs2
        clear_inputs();
        id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7;
        set_stage(1, 1, 7, 0);
        settle();
        chk("lu_stall", stall, 1);
        chk("lu_pc_we", pc_write_enable, 0);
        chk("lu_fwd2", forward_rs2, 0);
        tick();
        set_stage(1, 0, 0, 0);
        set_stage(2, 1, 7, 1);
        settle();
        chk("lu_fwd2_mem", forward_rs2, 2);
        chk("lu_release", stall, 0);

        // Mul to x9, latency 4: reader stalls 3 cycles
        issue_long(9, 4);
        clear_inputs();
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 9;
        settle();
        chk("raw_sb_busy", sb_busy, 1);
        chk("raw_pc_we", pc_write_enable, 0);
        count_stalls(n);
        chk("raw_lat4_cycles", n, 3);
        chk("raw_lat4_fwd", forward_rs1, 0);
        chk("raw_lat4_idle", sb_busy, 0);
        tick();

        // Maximum latency
        issue_long(9, 15);
        clear_inputs();
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 9;
        count_stalls(n);
        chk("raw_lat15_cycles", n, 14);
        tick();

        // WAW: counter at 2 when the writer reaches ID
        issue_long(9, 3);
        clear_inputs();
        id_valid = 1; id_write_reg = 1; id_rd = 9;
        count_stalls(n);
        chk("waw_cycles", n, 2);
        tick();

        // Writes to x0 are never tracked
        issue_long(0, 5);
        clear_inputs();
        settle();
        chk("x0_sb_busy", sb_busy, 0);

        // ex_branch_resolved while IDLE is ignored
        ex_branch_resolved = 1; ex_should_branch = 1;
        settle();
        chk("idle_res_flush", flush, 0);
        chk("idle_res_pc_we", pc_write_enable, 1);
        tick();

        // Taken branch
        clear_inputs();
        id_valid = 1; id_is_branch = 1;
        settle();
        chk("br_issue_stall", stall, 0);
        tick();
        id_is_branch = 0;
        settle();
        chk("br_res_stall", stall, 1);
        chk("br_res_pc_we", pc_write_enable, 0);
        chk("br_res_ifid_we", ifid_write_enable, 0);
        tick();
        ex_branch_resolved = 1; ex_should_branch = 1;
        settle();
        chk("br_taken_flush", flush, 1);
        chk("br_taken_pc_we", pc_write_enable, 1);
        chk("br_taken_stall", stall, 0);
        tick();
        clear_inputs();
        id_valid = 1;
        settle();
        chk("br_after_stall", stall, 0);
        chk("br_after_flush", flush, 0);

        // Not-taken branch
        clear_inputs();
        id_valid = 1; id_is_branch = 1;
        settle();
        tick();
        id_is_branch = 0;
        settle();
        chk("brnt_res_stall", stall, 1);
        tick();
        ex_branch_resolved = 1; ex_should_branch = 0;
        settle();
        chk("brnt_flush", flush, 0);
        chk("brnt_pc_we", pc_write_enable, 1);
        chk("brnt_stall", stall, 0);
        tick();

        // dmem_wait during RESOLVE with a counter at 5
        issue_long(12, 7);
        clear_inputs();
        id_valid = 1; id_is_branch = 1;
        settle();
        chk("dw_br_issue", stall, 0);
        tick();
        clear_inputs();
        id_valid = 1; dmem_wait = 1; ex_branch_resolved = 1; ex_should_branch = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("dw_pipe_en", pipe_enable, 0);
            chk("dw_hold_stall", stall, 1);
            chk("dw_hold_flush", flush, 0);
            chk("dw_hold_pc_we", pc_write_enable, 0);
            tick();
        end
        dmem_wait = 0; ex_branch_resolved = 0; ex_should_branch = 0;
        settle();
        chk("dw_still_resolve", stall, 1);
        chk("dw_cnt2_busy", sb_busy, 1);
        tick();
        settle();
        chk("dw_cnt1_busy", sb_busy, 1);
        tick();
        settle();
        chk("dw_cnt0_busy", sb_busy, 0);
        chk("dw_cnt0_stall", stall, 1);
        ex_branch_resolved = 1;
        settle();
        chk("dw_resolve_pc_we", pc_write_enable, 1);
        chk("dw_resolve_flush", flush, 0);
        chk("dw_resolve_stall", stall, 0);
        tick();

        // Reset while in RESOLVE with a pending counter
        issue_long(20, 10);
        clear_inputs();
        id_valid = 1; id_is_branch = 1;
        settle();
        tick();
        clear_inputs();
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 20;
        settle();
        chk("pre_rst_stall", stall, 1);
        chk("pre_rst_busy", sb_busy, 1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("post_rst_busy", sb_busy, 0);
        chk("post_rst_stall", stall, 0);
        chk("post_rst_pc_we", pc_write_enable, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
